param_stack_machine: RTL and testbench
======================================

// Module: param_stack_machine
// PURPOSE
//  Parametrised LIFO operand stack with byte, word, split-word, pop, replace, dup and clear ops.
//  One op per cycle, qualified by i_valid.
//  Status outputs: full, empty, count, wait and a sticky error flag.
//  Registered pop-data output with a valid strobe.
//  Sits between the instruction decoder (op source) and the datapath ALU (pop consumer).
// PARAMETERS
//  DATA_W  16  entry/data width; must be even (HALF = DATA_W/2)
//  DEPTH   8   number of stack entries; >= 2
//  CNT_W   $clog2(DEPTH+1)  width of o_count (derived localparam, not overridable)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  i_valid      in   1       op qualifier; i_op ignored when 0
//  i_op         in   3       operation code (see BEHAVIOUR)
//  DATA_in      in   DATA_W  push operand
//  DATA_out     out  DATA_W  last popped value, registered
//  o_out_valid  out  1       1-cycle pulse: DATA_out updated this cycle
//  o_top        out  DATA_W  current top entry; 0 when empty
//  o_count      out  CNT_W   occupied entries, 0..DEPTH
//  o_empty      out  1       o_count==0
//  o_full       out  1       o_count==DEPTH
//  o_wait       out  1       o_count>=DEPTH-1 (PUSH_SPLIT would not fit)
//  o_err        out  1       sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - All entries, DATA_out, o_count and o_err cleared; o_out_valid=0.
//   - Reset mid-op aborts the op; no partial update survives.
//  Op execution
//   - Accepted on rising clk when i_valid=1.
//   - Stack, count and DATA_out update on that edge (1-cycle latency).
//   - o_top, o_empty, o_full and o_wait are combinational from registered state.
//  Op codes
//   - 000 NOP: no change.
//   - 001 PUSH_BYTE: push {0, DATA_in[HALF-1:0]}; needs 1 free slot.
//   - 010 PUSH_WORD: push DATA_in; needs 1 free slot.
//   - 011 PUSH_SPLIT: push {0, DATA_in[DATA_W-1:HALF]}, then {0, DATA_in[HALF-1:0]}.
//       Low half ends on top; needs 2 free slots; count += 2 in one cycle.
//   - 100 POP: DATA_out <= top; o_out_valid=1 next cycle; count -= 1; vacated entry zeroed.
//   - 101 POP_PUSH: DATA_out <= top; top <= DATA_in; count unchanged; o_out_valid=1; needs count>=1.
//   - 110 DUP: push copy of top; needs count>=1 and 1 free slot.
//   - 111 CLEAR: count=0; all entries zeroed; o_err cleared; DATA_out held.
//  Error handling
//   - Illegal op: push when full, SPLIT when o_wait, POP/POP_PUSH/DUP when empty.
//   - Illegal op leaves stack, count and DATA_out unchanged and sets o_err=1.
//   - o_out_valid stays 0 on a rejected pop.
//   - o_err stays set until CLEAR or reset.
//  Outputs with no pop
//   - o_out_valid=0 on every cycle with no accepted pop.
//   - DATA_out holds its value between pops.
//  State
//   - One op per cycle; no internal multi-cycle FSM.
//   - Occupancy FSM is implicit in o_count.
//   - Boundaries: EMPTY(0), PARTIAL, NEAR_FULL(DEPTH-1), FULL(DEPTH).
//  Width rules
//   - Half-word pushes are zero-extended to DATA_W.
//   - Count never wraps; illegal ops are rejected, not saturated.
// TESTING
//  T1 reset: drive rst_n low mid-PUSH -> count=0, o_empty=1, o_top=0, o_err=0, DATA_out=0 immediately (async).
//  T2 split: PUSH_SPLIT 16'hA55A, POP, POP
//     -> DATA_out=16'h005A with o_out_valid, then 16'h00A5; o_empty=1 after.
//  T3 fill: 8x PUSH_WORD 1..8
//     -> o_full=1, o_top=8.
//     Then PUSH_WORD 9 -> o_err=1, o_top=8, count=8.
//  T4 near-full: 7 pushes (o_wait=1), then PUSH_SPLIT -> rejected, count=7, o_err=1.
//     Then CLEAR -> count=0, o_err=0.
//  T5 replace/dup: PUSH 16'h1234, DUP, POP_PUSH 16'hBEEF
//     -> DATA_out=16'h1234, o_top=16'hBEEF, count=2.
//  T6 underflow: POP on empty -> o_out_valid=0, DATA_out unchanged, o_err=1.
//     i_valid=0 with i_op=POP -> no change.

Source files
------------

// File: rtl/param_stack_machine.sv
// LIFO operand stack between the instruction decoder and the ALU.
// One op per cycle; illegal ops are rejected and raise a sticky error flag.
module param_stack_machine #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] DATA_in,
  output logic [DATA_W-1:0] DATA_out,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_top,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_wait,
  output logic              o_err
);

  localparam int HALF = DATA_W / 2;

  typedef enum logic [2:0] {
    OP_NOP        = 3'b000,
    OP_PUSH_BYTE  = 3'b001,
    OP_PUSH_WORD  = 3'b010,
    OP_PUSH_SPLIT = 3'b011,
    OP_POP        = 3'b100,
    OP_POP_PUSH   = 3'b101,
    OP_DUP        = 3'b110,
    OP_CLEAR      = 3'b111
  } op_e;

  op_e op;
  assign op = op_e'(i_op);

  // Entry 0 is the bottom; the top lives at index count-1.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic [DATA_W-1:0] dout_q, dout_nxt;
  logic              ov_q, ov_nxt;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] top;

  logic              do_push, do_split, do_pop, do_repl, do_clear, bad;
  logic [DATA_W-1:0] push_val, lo_ext, hi_ext;
  logic              is_empty, is_full, is_wait;

  assign lo_ext = {{(DATA_W - HALF){1'b0}}, DATA_in[HALF-1:0]};
  assign hi_ext = {{HALF{1'b0}}, DATA_in[DATA_W-1:HALF]};

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_wait  = (count >= CNT_W'(DEPTH - 1));

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) + CNT_W'(1) == count) top = mem[i];
    end
  end

  // Decode the op into legality-checked actions.
  always_comb begin
    do_push  = 1'b0;
    do_split = 1'b0;
    do_pop   = 1'b0;
    do_repl  = 1'b0;
    do_clear = 1'b0;
    bad      = 1'b0;
    push_val = DATA_in;
    if (i_valid) begin
      unique case (op)
        OP_NOP: ;
        OP_PUSH_BYTE: begin
          push_val = lo_ext;
          if (is_full) bad = 1'b1; else do_push = 1'b1;
        end
        OP_PUSH_WORD: begin
          if (is_full) bad = 1'b1; else do_push = 1'b1;
        end
        OP_PUSH_SPLIT: begin
          if (is_wait) bad = 1'b1; else do_split = 1'b1;
        end
        OP_POP: begin
          if (is_empty) bad = 1'b1; else do_pop = 1'b1;
        end
        OP_POP_PUSH: begin
          if (is_empty) bad = 1'b1; else do_repl = 1'b1;
        end
        OP_DUP: begin
          push_val = top;
          if (is_empty || is_full) bad = 1'b1; else do_push = 1'b1;
        end
        OP_CLEAR: do_clear = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_nxt  = mem;
    cnt_nxt  = count;
    dout_nxt = dout_q;
    ov_nxt   = 1'b0;
    err_nxt  = err_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_push  && CNT_W'(i) == count)                 mem_nxt[i] = push_val;
      if (do_split && CNT_W'(i) == count)                 mem_nxt[i] = hi_ext;
      if (do_split && CNT_W'(i) == count + CNT_W'(1))     mem_nxt[i] = lo_ext;
      if (do_pop   && CNT_W'(i) + CNT_W'(1) == count)     mem_nxt[i] = '0;
      if (do_repl  && CNT_W'(i) + CNT_W'(1) == count)     mem_nxt[i] = DATA_in;
      if (do_clear)                                       mem_nxt[i] = '0;
    end
    if (do_push)  cnt_nxt = count + CNT_W'(1);
    if (do_split) cnt_nxt = count + CNT_W'(2);
    if (do_pop)   cnt_nxt = count - CNT_W'(1);
    if (do_clear) cnt_nxt = '0;
    if (do_pop || do_repl) begin
      dout_nxt = top;
      ov_nxt   = 1'b1;
    end
    if (bad)      err_nxt = 1'b1;
    if (do_clear) err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      count  <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mem    <= mem_nxt;
      count  <= cnt_nxt;
      dout_q <= dout_nxt;
      ov_q   <= ov_nxt;
      err_q  <= err_nxt;
    end
  end

  assign DATA_out    = dout_q;
  assign o_out_valid = ov_q;
  assign o_top       = top;
  assign o_count     = count;
  assign o_empty     = is_empty;
  assign o_full      = is_full;
  assign o_wait      = is_wait;
  assign o_err       = err_q;

endmodule

// File: tb/tb_param_stack_machine.sv
// Bench for param_stack_machine: directed scenarios plus random ops,
// checked against a queue-based reference model of the stack.
module tb_param_stack_machine;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int HALF  = DW / 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PBYTE = 3'd1, PWORD = 3'd2, PSPLIT = 3'd3,
                         POP = 3'd4, POPPUSH = 3'd5, DUP = 3'd6, CLR = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic [2:0]       i_op = 3'd0;
  logic [DW-1:0]    DATA_in = '0;
  logic [DW-1:0]    DATA_out;
  logic             o_out_valid;
  logic [DW-1:0]    o_top;
  logic [CNT_W-1:0] o_count;
  logic             o_empty, o_full, o_wait, o_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_dout;
  logic          m_ov;
  logic          m_err;

  param_stack_machine #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_op(i_op), .DATA_in(DATA_in),
    .DATA_out(DATA_out), .o_out_valid(o_out_valid), .o_top(o_top), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full), .o_wait(o_wait), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    stk.delete();
    m_dout = '0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_apply(input logic v, input logic [2:0] op, input logic [DW-1:0] d);
    logic [DW-1:0] lo, hi;
    int n;
    lo = DW'(d[HALF-1:0]);
    hi = DW'(d[DW-1:HALF]);
    n  = stk.size();
    m_ov = 1'b0;
    if (!v) return;
    case (op)
      PBYTE:   if (n < DEPTH) stk.push_back(lo); else m_err = 1'b1;
      PWORD:   if (n < DEPTH) stk.push_back(d); else m_err = 1'b1;
      PSPLIT:  if (n + 2 <= DEPTH) begin stk.push_back(hi); stk.push_back(lo); end
               else m_err = 1'b1;
      POP:     if (n > 0) begin m_dout = stk.pop_back(); m_ov = 1'b1; end
               else m_err = 1'b1;
      POPPUSH: if (n > 0) begin m_dout = stk[n-1]; stk[n-1] = d; m_ov = 1'b1; end
               else m_err = 1'b1;
      DUP:     if (n > 0 && n < DEPTH) stk.push_back(stk[n-1]); else m_err = 1'b1;
      CLR:     begin stk.delete(); m_err = 1'b0; end
      default: ;
    endcase
  endfunction

  task automatic expect_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_top;
    int n;
    n = stk.size();
    exp_top = (n > 0) ? stk[n-1] : '0;
    expect_val({tag, ".dout"},  DATA_out, m_dout);
    expect_val({tag, ".ov"},    DW'(o_out_valid), DW'(m_ov));
    expect_val({tag, ".top"},   o_top, exp_top);
    expect_val({tag, ".count"}, DW'(o_count), DW'(n));
    expect_val({tag, ".empty"}, DW'(o_empty), DW'(n == 0));
    expect_val({tag, ".full"},  DW'(o_full), DW'(n == DEPTH));
    expect_val({tag, ".wait"},  DW'(o_wait), DW'(n >= DEPTH - 1));
    expect_val({tag, ".err"},   DW'(o_err), DW'(m_err));
  endtask

  task automatic do_op(input logic v, input logic [2:0] op, input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    i_valid = v;
    i_op    = op;
    DATA_in = d;
    @(posedge clk);
    model_apply(v, op, d);
    #1;
    check_all(tag);
    i_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]    rop;
    logic [DW-1:0] rd;
    logic          rv;

    // Power-up reset
    model_reset();
    #12;
    check_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: set up state, then assert reset in the middle of a push
    do_op(1'b1, PWORD, 16'h1111, "t1_push");
    do_op(1'b1, PWORD, 16'h2222, "t1_push2");
    do_op(1'b1, POP,   16'h0,    "t1_pop");
    do_op(1'b1, CLR,   16'h0,    "t1_clr");
    do_op(1'b1, POP,   16'h0,    "t1_underflow");
    do_op(1'b1, PWORD, 16'h3333, "t1_push3");
    @(negedge clk);
    i_valid = 1'b1; i_op = PWORD; DATA_in = 16'h4444;
    #2 rst_n = 1'b0;
    #1;
    expect_val("t1.count", DW'(o_count), '0);
    expect_val("t1.empty", DW'(o_empty), 16'd1);
    expect_val("t1.top",   o_top, '0);
    expect_val("t1.err",   DW'(o_err), '0);
    expect_val("t1.dout",  DATA_out, '0);
    model_reset();
    @(posedge clk); #1;
    check_all("t1_held");
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: split push, low half on top
    do_op(1'b1, PSPLIT, 16'hA55A, "t2_split");
    do_op(1'b1, POP, 16'h0, "t2_pop1");
    expect_val("t2.dout1", DATA_out, 16'h005A);
    expect_val("t2.ov1", DW'(o_out_valid), 16'd1);
    do_op(1'b1, POP, 16'h0, "t2_pop2");
    expect_val("t2.dout2", DATA_out, 16'h00A5);
    expect_val("t2.empty", DW'(o_empty), 16'd1);
    do_op(1'b1, NOP, 16'h0, "t2_idle");
    expect_val("t2.ov_drop", DW'(o_out_valid), '0);

    // T3: fill to full, then overflow
    for (int i = 1; i <= DEPTH; i++) do_op(1'b1, PWORD, DW'(i), "t3_fill");
    expect_val("t3.full", DW'(o_full), 16'd1);
    expect_val("t3.top", o_top, 16'd8);
    do_op(1'b1, PWORD, 16'd9, "t3_over");
    expect_val("t3.err", DW'(o_err), 16'd1);
    expect_val("t3.top2", o_top, 16'd8);
    expect_val("t3.count", DW'(o_count), 16'd8);
    do_op(1'b1, DUP, 16'h0, "t3_dup_full");
    do_op(1'b1, CLR, 16'h0, "t3_clr");

    // T4: near-full split rejection, then clear
    for (int i = 0; i < DEPTH - 1; i++) do_op(1'b1, PBYTE, 16'hFF00 | DW'(i), "t4_fill");
    expect_val("t4.wait", DW'(o_wait), 16'd1);
    expect_val("t4.top_zext", o_top, 16'h0006);
    do_op(1'b1, PSPLIT, 16'h1234, "t4_split");
    expect_val("t4.count", DW'(o_count), 16'd7);
    expect_val("t4.err", DW'(o_err), 16'd1);
    do_op(1'b1, CLR, 16'h0, "t4_clr");
    expect_val("t4.count0", DW'(o_count), '0);
    expect_val("t4.err0", DW'(o_err), '0);

    // T5: replace and dup
    do_op(1'b1, PWORD, 16'h1234, "t5_push");
    do_op(1'b1, DUP, 16'h0, "t5_dup");
    do_op(1'b1, POPPUSH, 16'hBEEF, "t5_poppush");
    expect_val("t5.dout", DATA_out, 16'h1234);
    expect_val("t5.top", o_top, 16'hBEEF);
    expect_val("t5.count", DW'(o_count), 16'd2);
    do_op(1'b1, CLR, 16'h0, "t5_clr");
    expect_val("t5.dout_held", DATA_out, 16'h1234);

    // T6: underflow and ignored op
    do_op(1'b1, POP, 16'h0, "t6_under");
    expect_val("t6.ov", DW'(o_out_valid), '0);
    expect_val("t6.dout", DATA_out, 16'h1234);
    expect_val("t6.err", DW'(o_err), 16'd1);
    do_op(1'b1, POPPUSH, 16'h5555, "t6_pp_empty");
    do_op(1'b1, DUP, 16'h0, "t6_dup_empty");
    do_op(1'b1, PWORD, 16'h7777, "t6_push");
    do_op(1'b0, POP, 16'h0, "t6_novalid");
    expect_val("t6.novalid_cnt", DW'(o_count), 16'd1);
    expect_val("t6.novalid_ov", DW'(o_out_valid), '0);

    // Random ops against the model
    for (int k = 0; k < 400; k++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == CLR && $urandom_range(0, 5) != 0) rop = PWORD;
      rd  = DW'($urandom);
      rv  = ($urandom_range(0, 9) != 0);
      do_op(rv, rop, rd, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
